// File: rtl/uart_tx.sv
// 8N1 serial transmitter: accepts one DATA_BITS word per valid/ready handshake
// and shifts it out LSB first at CLKS_PER_BIT clocks per bit.
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx_out,
  output logic                 busy
);

  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BIT_W  = $clog2(DATA_BITS);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]           state_q,    state_d;
  logic [BAUD_W-1:0]    baud_q,     baud_d;
  logic [BIT_W-1:0]     bit_q,      bit_d;
  logic [DATA_BITS-1:0] shift_q,    shift_d;
  logic                 tx_out_q,   tx_out_d;
  logic                 tx_ready_q, tx_ready_d;
  logic                 busy_q,     busy_d;
  logic                 baud_end;

  // Next-state logic; outputs are derived from the next state so they land
  // registered in the same cycle the state takes effect.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    baud_end = (baud_q == BAUD_LAST);

    case (state_q)
      S_IDLE: begin
        if (tx_valid && tx_ready_q) begin
          state_d = S_START;
          shift_d = tx_data;
          baud_d  = '0;
          bit_d   = '0;
        end
      end
      S_START: begin
        if (baud_end) begin
          state_d = S_DATA;
          baud_d  = '0;
          bit_d   = '0;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      S_DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == BIT_LAST) begin
            state_d = S_STOP;
          end else begin
            bit_d   = bit_q + BIT_W'(1);
            shift_d = shift_q >> 1;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: begin
        if (baud_end) begin
          state_d = S_IDLE;
          baud_d  = '0;
          bit_d   = '0;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
    endcase

    tx_ready_d = (state_d == S_IDLE);
    busy_d     = (state_d != S_IDLE);
    case (state_d)
      S_START: tx_out_d = 1'b0;
      S_DATA:  tx_out_d = shift_d[0];
      default: tx_out_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      tx_out_q   <= 1'b1;
      tx_ready_q <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      tx_out_q   <= tx_out_d;
      tx_ready_q <= tx_ready_d;
      busy_q     <= busy_d;
    end
  end

  assign tx_out   = tx_out_q;
  assign tx_ready = tx_ready_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: expected line bits are queued at acceptance and
// compared cycle by cycle while the frame plays out.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       v4, v2;
  logic [7:0] d4, d2;
  logic       rdy4, out4, busy4;
  logic       rdy2, out2, busy2;

  int n_assert = 0;
  int n_fail   = 0;
  logic exp_q[$];

  always #5 clk = ~clk;

  uart_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .tx_valid(v4), .tx_data(d4),
    .tx_ready(rdy4), .tx_out(out4), .busy(busy4)
  );

  uart_tx #(.CLKS_PER_BIT(2), .DATA_BITS(8)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .tx_valid(v2), .tx_data(d2),
    .tx_ready(rdy2), .tx_out(out2), .busy(busy2)
  );

  task automatic check(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input bit sel, input string tag);
    check({tag, "_out"},   sel ? out2  : out4,  1'b1);
    check({tag, "_ready"}, sel ? rdy2  : rdy4,  1'b1);
    check({tag, "_busy"},  sel ? busy2 : busy4, 1'b0);
  endtask

  // Queue the expected line bits and present the word for one accepting edge.
  task automatic start_frame(input bit sel, input logic [7:0] data, input bit hold);
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(data[i]);
    exp_q.push_back(1'b1);
    if (sel) begin v2 = 1'b1; d2 = data; end
    else     begin v4 = 1'b1; d4 = data; end
    tick();
    if (!hold) begin v2 = 1'b0; v4 = 1'b0; end
  endtask

  // Compare ncyc frame cycles; a full frame is followed by an idle-cycle check.
  task automatic check_frame(input bit sel, input int cpb, input int ncyc, input int poke_at);
    logic cur;
    cur = 1'b1;
    for (int c = 0; c < ncyc; c++) begin
      if (c % cpb == 0) begin
        if (exp_q.size() == 0) check("sb_empty", 1'b1, 1'b0);
        else cur = exp_q.pop_front();
      end
      if (c == poke_at) begin v4 = 1'b1; d4 = 8'h3C; end
      if (c == poke_at + 1) v4 = 1'b0;
      check("line",  sel ? out2  : out4,  cur);
      check("busy",  sel ? busy2 : busy4, 1'b1);
      check("ready", sel ? rdy2  : rdy4,  1'b0);
      tick();
    end
    if (ncyc == 10 * cpb) check_idle(sel, "post_frame");
  endtask

  initial begin
    reset_n = 1'b0;
    v4 = 1'b1; d4 = 8'h99;
    v2 = 1'b0; d2 = 8'h00;

    // Reset held 3 cycles with a request present; it must not be taken.
    repeat (3) tick();
    check_idle(1'b0, "reset4");
    check_idle(1'b1, "reset2");
    v4 = 1'b0;

    // Single byte, requested on the first cycle after release.
    reset_n = 1'b1;
    start_frame(1'b0, 8'hA5, 1'b0);
    check_frame(1'b0, 4, 40, -1);

    // Back-to-back: valid held through frame 1, second start after one idle cycle.
    start_frame(1'b0, 8'h00, 1'b1);
    check_frame(1'b0, 4, 40, -1);
    start_frame(1'b0, 8'hFF, 1'b0);
    check_frame(1'b0, 4, 40, -1);

    // Stale data and a request while busy are both ignored.
    start_frame(1'b0, 8'h81, 1'b0);
    check_frame(1'b0, 4, 40, 6);
    for (int i = 0; i < 12; i++) begin
      check_idle(1'b0, "no_second");
      tick();
    end

    // Reset during data bit 3 aborts the frame.
    start_frame(1'b0, 8'h55, 1'b0);
    check_frame(1'b0, 4, 18, -1);
    exp_q.delete();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check_idle(1'b0, "abort");
    start_frame(1'b0, 8'h0F, 1'b0);
    check_frame(1'b0, 4, 40, -1);

    // Minimum divider instance.
    start_frame(1'b1, 8'hC3, 1'b0);
    check_frame(1'b1, 2, 20, -1);

    // Idle line after reset.
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      check_idle(1'b0, "idle");
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
